// File: rtl/i2c_pkg.sv
// Shared types and constants for the SCCB/I2C write master: FSM states,
// quarter-phase encoding and the bus-level decode used to register SCL/SDA.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_BOOT = 4'd0,
    ST_IDLE      = 4'd1,
    ST_START     = 4'd2,
    ST_SLV       = 4'd3,
    ST_ACK1      = 4'd4,
    ST_REG       = 4'd5,
    ST_ACK2      = 4'd6,
    ST_DAT       = 4'd7,
    ST_ACK3      = 4'd8,
    ST_STOP      = 4'd9,
    ST_DONE      = 4'd10
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE_BIT = 1'b0;

  typedef struct packed {
    logic scl;
    logic sda_oe;
  } bus_t;

  // SCL is high in q2/q3 of every slot except START, where it stays high.
  function automatic bus_t bus_levels(input i2c_state_e st,
                                      input logic [1:0]  ph,
                                      input logic        tx_bit);
    bus_t b;
    b.scl    = 1'b1;
    b.sda_oe = 1'b0;
    case (st)
      ST_START: b.sda_oe = ph[1];
      ST_SLV, ST_REG, ST_DAT: begin
        b.scl    = ph[1];
        b.sda_oe = ~tx_bit;
      end
      ST_ACK1, ST_ACK2, ST_ACK3: b.scl = ph[1];
      ST_STOP: begin
        b.scl    = ph[1];
        b.sda_oe = (ph != Q3);
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter timebase: divides i_clk by DIV and steps a 2-bit phase q0..q3.
// Held at count 0 / q0 while disabled so every transfer starts on a slot edge.
module i2c_quarter_tick #(
  parameter int DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);
  import i2c_pkg::*;

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  // NOTE: reset is synchronous and sampled inside the clocked block, so it
  // appears in the if-chain rather than in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (i_rst || !en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_sccb_write_master.sv
// SCCB/I2C 3-byte write engine: START, slave+W, reg_addr, reg_data, STOP on an
// open-drain pair, with a one-cycle done strobe after boot and each transfer.
module i2c_sccb_write_master #(
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         I2C_FREQ       = 100_000,
  parameter logic [6:0] SLAVE_ADDR     = 7'h21,
  parameter int         STARTUP_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_i2c_req,
  input  logic [15:0] i_i2c_data,
  output logic        o_i2c_done,
  output logic        o_ack_err,
  output logic        o_busy,
  output logic        o_scl,
  output logic        o_sda_oe,
  input  logic        i_sda
);
  import i2c_pkg::*;

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int BW  = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  i2c_state_e    state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [15:0]   data_q, data_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] boot_q, boot_d;
  logic          done_d, err_d, busy_d;
  bus_t          bus_d;

  logic       tick_en, tick;
  logic [1:0] phase, phase_d;
  logic       slot_end, ack_sample, last_bit;

  assign tick_en = !(state_q inside {ST_WAIT_BOOT, ST_IDLE, ST_DONE});

  i2c_quarter_tick #(.DIV(DIV)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .en    (tick_en),
    .tick  (tick),
    .phase (phase)
  );

  assign phase_d    = tick ? phase + 2'd1 : phase;
  assign slot_end   = tick && (phase == Q3);
  assign ack_sample = tick && (phase == Q1);
  assign last_bit   = slot_end && (bit_cnt_q == 3'd7);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    boot_d    = boot_q;
    done_d    = 1'b0;
    err_d     = o_ack_err;
    busy_d    = o_busy;

    case (state_q)
      ST_WAIT_BOOT: begin
        if (boot_q == BW'(STARTUP_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end

      // A req coinciding with the boot done strobe is dropped like any other.
      ST_IDLE: begin
        if (i_i2c_req && !o_i2c_done) begin
          data_d    = i_i2c_data;
          shreg_d   = {SLAVE_ADDR, I2C_WRITE_BIT};
          bit_cnt_d = 3'd0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (slot_end) state_d = ST_SLV;
      end

      ST_SLV, ST_REG, ST_DAT: begin
        if (slot_end) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (last_bit) begin
          case (state_q)
            ST_SLV:  state_d = ST_ACK1;
            ST_REG:  state_d = ST_ACK2;
            default: state_d = ST_ACK3;
          endcase
        end
      end

      // A NACK sampled at q2 is already in o_ack_err by the slot end.
      ST_ACK1, ST_ACK2, ST_ACK3: begin
        if (ack_sample && i_sda) err_d = 1'b1;
        if (slot_end) begin
          if (o_ack_err || state_q == ST_ACK3) begin
            state_d = ST_STOP;
          end else if (state_q == ST_ACK1) begin
            shreg_d = data_q[15:8];
            state_d = ST_REG;
          end else begin
            shreg_d = data_q[7:0];
            state_d = ST_DAT;
          end
        end
      end

      ST_STOP: begin
        if (slot_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_WAIT_BOOT;
    endcase
  end

  // Bus pins are registered from next-state values so they change exactly
  // at quarter boundaries and never glitch.
  always_comb bus_d = bus_levels(state_d, phase_d, shreg_d[7]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_WAIT_BOOT;
      bit_cnt_q  <= 3'd0;
      boot_q     <= '0;
      o_i2c_done <= 1'b0;
      o_ack_err  <= 1'b0;
      o_busy     <= 1'b0;
      o_scl      <= 1'b1;
      o_sda_oe   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      boot_q     <= boot_d;
      o_i2c_done <= done_d;
      o_ack_err  <= err_d;
      o_busy     <= busy_d;
      o_scl      <= bus_d.scl;
      o_sda_oe   <= bus_d.sda_oe;
    end
  end

  // NOTE: the data path is left unreset; it is always loaded on request
  // acceptance before anything reads it.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
    data_q  <= data_d;
  end

endmodule

// File: tb/tb_i2c_sccb_write_master.sv
// Scoreboard bench for i2c_sccb_write_master: stimulus pushes expected frames,
// a bus monitor with an acking slave decodes SCL/SDA and checks on each done.
module tb_i2c_sccb_write_master;

  localparam int CLK_FREQ = 4_000_000;
  localparam int I2C_FREQ = 250_000;
  localparam int STARTUP  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        done, ack_err, busy, scl, sda_oe;
  logic        slave_low = 1'b0;
  logic        sda;
  logic [2:0]  slave_mask = 3'b111;

  assign sda = !(sda_oe || slave_low);

  i2c_sccb_write_master #(
    .CLK_FREQ       (CLK_FREQ),
    .I2C_FREQ       (I2C_FREQ),
    .SLAVE_ADDR     (7'h21),
    .STARTUP_CYCLES (STARTUP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_i2c_req  (req),
    .i_i2c_data (data),
    .o_i2c_done (done),
    .o_ack_err  (ack_err),
    .o_busy     (busy),
    .o_scl      (scl),
    .o_sda_oe   (sda_oe),
    .i_sda      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit          is_frame;
    int          ref_cyc;
    int          lat;
    int          nbits;
    logic [23:0] bytes;
    bit          err;
  } exp_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  mask;
    logic [23:0] bytes;
    int          nbits;
    int          lat;
    bit          err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs [10];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_boot();
    sb_q.push_back('{1'b0, cyc, STARTUP, 0, 24'h0, 1'b0});
  endtask

  task automatic issue(input vec_t v, input bit accept);
    @(posedge clk); #1;
    req  = 1'b1;
    data = v.data;
    if (accept) sb_q.push_back('{1'b1, cyc, v.lat, v.nbits, v.bytes, v.err});
    @(posedge clk); #1;
    req  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    check("done_within_budget", done, 1);
  endtask

  // Bus monitor, acking slave and scoreboard comparison.
  initial begin : monitor
    bit          in_frame, pending, pend_val, stop_seen, have_stop;
    bit          prev_scl, prev_sda, prev_busy;
    int          nbits, gap;
    logic [26:0] bits;
    exp_t        e;
    in_frame = 0; pending = 0; pend_val = 0; stop_seen = 0; have_stop = 0;
    prev_scl = 1; prev_sda = 1; prev_busy = 0; nbits = 0; gap = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 0;
        pending   = 0;
        stop_seen = 0;
        have_stop = 0;
        nbits     = 0;
        slave_low = 1'b0;
        prev_scl  = 1;
        prev_sda  = 1;
        prev_busy = 0;
      end else begin
        if (prev_scl && scl && prev_sda && !sda) begin
          if (have_stop) check("idle_gap_before_start", gap >= 1, 1);
          in_frame  = 1;
          stop_seen = 0;
          have_stop = 0;
          nbits     = 0;
          bits      = '0;
          pending   = 0;
        end else if (in_frame && prev_scl && scl && !prev_sda && sda) begin
          in_frame  = 0;
          stop_seen = 1;
          have_stop = 1;
          pending   = 0;
          gap       = 0;
        end else if (in_frame) begin
          if (!prev_scl && scl) begin
            pending  = 1;
            pend_val = sda;
          end else if (prev_scl && !scl && pending) begin
            pending = 0;
            if (nbits < 27) bits[26 - nbits] = pend_val;
            nbits++;
            if (nbits % 9 == 8)      slave_low = slave_mask[nbits / 9];
            else if (nbits % 9 == 0) slave_low = 1'b0;
          end
        end else if (have_stop && scl && sda) begin
          gap++;
        end

        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("done_latency", cyc - e.ref_cyc, e.lat);
            check("busy_low_at_done", busy, 0);
            check("bus_idle_at_done", {scl, sda}, 2'b11);
            if (e.is_frame) begin
              check("busy_before_done", prev_busy, 1);
              check("stop_seen", stop_seen, 1);
              check("bits_clocked", nbits, e.nbits);
              check("ack_err", ack_err, e.err);
              check("slave_byte", bits[26:19], e.bytes[23:16]);
              if (e.nbits >= 18) check("reg_byte", bits[17:10], e.bytes[15:8]);
              if (e.nbits >= 27) check("data_byte", bits[8:1], e.bytes[7:0]);
            end
          end
        end
        prev_busy = busy;
        prev_scl  = scl;
        prev_sda  = sda;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    //           data      ack mask  bytes on bus  bits lat  err
    vecs[0] = '{16'h1280, 3'b111, 24'h421280, 27, 465, 1'b0};
    vecs[1] = '{16'h5A3C, 3'b101, 24'h425A00, 18, 321, 1'b1};
    vecs[2] = '{16'hA55A, 3'b111, 24'h42A55A, 27, 465, 1'b0};
    vecs[3] = '{16'hFFFF, 3'b111, 24'h42FFFF, 27, 465, 1'b0};
    vecs[4] = '{16'h7777, 3'b110, 24'h420000,  9, 177, 1'b1};
    vecs[5] = '{16'h0F0F, 3'b011, 24'h420F0F, 27, 465, 1'b1};
    vecs[6] = '{16'h3C0F, 3'b111, 24'h423C0F, 27, 465, 1'b0};
    vecs[7] = '{16'h0102, 3'b111, 24'h420102, 27, 465, 1'b0};
    vecs[8] = '{16'hFE7F, 3'b111, 24'h42FE7F, 27, 465, 1'b0};
    vecs[9] = '{16'h55AA, 3'b111, 24'h4255AA, 27, 465, 1'b0};

    // Reset values, then boot done after STARTUP cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_boot();
    wait_done(40);

    // Full write, every byte acked.
    slave_mask = vecs[0].mask;
    issue(vecs[0], 1);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    wait_done(600);

    // NACK on the register byte: abort to STOP, error held until next req.
    slave_mask = vecs[1].mask;
    issue(vecs[1], 1);
    wait_done(600);
    @(negedge clk);
    check("ack_err_held_in_idle", ack_err, 1);

    // New request clears the error; a request while busy is ignored.
    slave_mask = vecs[2].mask;
    issue(vecs[2], 1);
    @(negedge clk);
    check("ack_err_cleared_on_accept", ack_err, 0);
    repeat (100) @(posedge clk);
    issue(vecs[3], 0);
    @(negedge clk);
    check("busy_during_ignored_req", busy, 1);
    wait_done(600);

    // NACK on the slave address, then NACK on the data byte.
    slave_mask = vecs[4].mask;
    issue(vecs[4], 1);
    wait_done(600);
    slave_mask = vecs[5].mask;
    issue(vecs[5], 1);
    wait_done(600);

    // Reset in the middle of the register byte aborts immediately.
    slave_mask = vecs[6].mask;
    issue(vecs[6], 0);
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_boot();
    @(negedge clk);
    check("abort_scl_released", scl, 1);
    check("abort_sda_released", sda_oe, 0);
    check("abort_busy_low", busy, 0);
    wait_done(40);

    // Sequencer loop: each req the cycle after done.
    for (int i = 7; i < 10; i++) begin
      slave_mask = vecs[i].mask;
      issue(vecs[i], 1);
      wait_done(600);
    end

    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("final_bus_idle", {scl, sda_oe, busy}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
